serial_subtractor: RTL

//  Bit-serial subtractor. Computes diff = a - b - bin one bit per clock, LSB first, through a single full-subtractor cell.
//  The borrow is held in a flip-flop between cycles. This is the subtract-direction counterpart of the full_adder cell in the adders/subtractors library.

---
 rtl/serial_subtractor_pkg.sv | 15 +
 rtl/serial_subtractor_if.sv | 25 ++
 rtl/serial_subtractor_full_subtractor.sv | 12 +
 rtl/serial_subtractor.sv | 109 ++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings and
// the legal operand width range.
`timescale 1ns/1ps
package serial_subtractor_pkg;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus between a controlling FSM
// (master) and the serial subtractor (slave).
`timescale 1ns/1ps
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: x - y - bi -> difference d, borrow-out bo.
`timescale 1ns/1ps
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock LSB first,
// through one full-subtractor cell with the borrow held in a flop.
`timescale 1ns/1ps
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_subtractor_if.slave bus
);
  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:1] res_sh_reg;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] diff_reg;
  logic [CW-1:0]    cnt_reg;
  logic             borrow_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             bout_reg;
  logic             d_bit;
  logic             bo_bit;

  full_subtractor u_cell (
    .x  (a_sh_reg[0]),
    .y  (b_sh_reg[0]),
    .bi (borrow_reg),
    .d  (d_bit),
    .bo (bo_bit)
  );

  // The oldest result bit would fall off the bottom on the last shift, so the
  // partial-result register only needs WIDTH-1 bits; the full word is formed here.
  assign res_next = {d_bit, res_sh_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      res_sh_reg <= '0;
      diff_reg   <= '0;
      cnt_reg    <= '0;
      borrow_reg <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      bout_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            a_sh_reg   <= bus.a;
            b_sh_reg   <= bus.b;
            borrow_reg <= bus.bin;
            cnt_reg    <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_sh_reg   <= a_sh_reg >> 1;
          b_sh_reg   <= b_sh_reg >> 1;
          res_sh_reg <= res_next[WIDTH-1:1];
          borrow_reg <= bo_bit;
          cnt_reg    <= cnt_reg + CW'(1);
          // diff/bout only move here so RUN never exposes a partial word.
          if (cnt_reg == LAST) begin
            diff_reg  <= res_next;
            bout_reg  <= bo_bit;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            a_sh_reg   <= bus.a;
            b_sh_reg   <= bus.b;
            borrow_reg <= bus.bin;
            cnt_reg    <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= ST_RUN;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.diff = diff_reg;
  assign bus.bout = bout_reg;

endmodule
